// File: rtl/opcode_fetch_mod.sv
// rtl/opcode_fetch_mod.sv - LR35902 instruction fetch front end with PC ownership and redirect
// Optional illegal-opcode trap: define OPFETCH_ILLEGAL_TRAP_EN.
module opcode_fetch_mod #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  opcode,
    output logic        cb_prefix,
    output logic [15:0] imm,
    output logic [15:0] instr_pc,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val
`ifdef OPFETCH_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    localparam logic [2:0] FETCH_OP = 3'd0;
    localparam logic [2:0] FETCH_CB = 3'd1;
    localparam logic [2:0] FETCH_LO = 3'd2;
    localparam logic [2:0] FETCH_HI = 3'd3;
    localparam logic [2:0] HOLD     = 3'd4;
`ifdef OPFETCH_ILLEGAL_TRAP_EN
    localparam logic [2:0] TRAP     = 3'd5;
`endif

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic        cb_q, cb_d;
    logic [15:0] imm_q, imm_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        hi_pend_q, hi_pend_d;

    logic fetching;
    logic take;
    logic len2;
    logic len3;
`ifdef OPFETCH_ILLEGAL_TRAP_EN
    logic is_illegal;
`endif

    always_comb begin
        len2 = 1'b0;
        len3 = 1'b0;
        case (mem_rdata)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8: len2 = 1'b1;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
            8'hEA, 8'hFA: len3 = 1'b1;
            default: ;
        endcase
    end

`ifdef OPFETCH_ILLEGAL_TRAP_EN
    always_comb begin
        is_illegal = 1'b0;
        case (mem_rdata)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: is_illegal = 1'b1;
            default: ;
        endcase
    end
`endif

    assign fetching = (state_q == FETCH_OP) || (state_q == FETCH_CB) ||
                      (state_q == FETCH_LO) || (state_q == FETCH_HI);
    assign take     = fetching && mem_ack;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        opcode_d   = opcode_q;
        cb_d       = cb_q;
        imm_d      = imm_q;
        instr_pc_d = instr_pc_q;
        hi_pend_d  = hi_pend_q;
        // Redirect wins over any ack or handoff in the same cycle.
        if (pc_load) begin
            pc_d    = pc_load_val;
            state_d = FETCH_OP;
        end else begin
            if (take) begin
                pc_d = pc_q + 16'd1;
            end
            case (state_q)
                FETCH_OP: if (take) begin
                    opcode_d   = mem_rdata;
                    instr_pc_d = pc_q;
                    imm_d      = 16'h0000;
                    cb_d       = 1'b0;
                    hi_pend_d  = len3;
                    if (mem_rdata == 8'hCB) begin
                        state_d = FETCH_CB;
`ifdef OPFETCH_ILLEGAL_TRAP_EN
                    end else if (is_illegal) begin
                        state_d = TRAP;
`endif
                    end else if (len2 || len3) begin
                        state_d = FETCH_LO;
                    end else begin
                        state_d = HOLD;
                    end
                end
                FETCH_CB: if (take) begin
                    opcode_d = mem_rdata;
                    cb_d     = 1'b1;
                    state_d  = HOLD;
                end
                FETCH_LO: if (take) begin
                    imm_d[7:0] = mem_rdata;
                    state_d    = hi_pend_q ? FETCH_HI : HOLD;
                end
                FETCH_HI: if (take) begin
                    imm_d[15:8] = mem_rdata;
                    state_d     = HOLD;
                end
                HOLD: if (instr_ready) begin
                    state_d = FETCH_OP;
                end
`ifdef OPFETCH_ILLEGAL_TRAP_EN
                TRAP: state_d = TRAP;
`endif
                default: state_d = FETCH_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_OP;
            pc_q       <= RESET_PC;
            opcode_q   <= 8'h00;
            cb_q       <= 1'b0;
            imm_q      <= 16'h0000;
            instr_pc_q <= RESET_PC;
            hi_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            opcode_q   <= opcode_d;
            cb_q       <= cb_d;
            imm_q      <= imm_d;
            instr_pc_q <= instr_pc_d;
            hi_pend_q  <= hi_pend_d;
        end
    end

    // Gated with rst_n so no read is requested while reset is held.
    assign mem_rd      = fetching && rst_n;
    assign mem_addr    = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign opcode      = opcode_q;
    assign cb_prefix   = cb_q;
    assign imm         = imm_q;
    assign instr_pc    = instr_pc_q;
`ifdef OPFETCH_ILLEGAL_TRAP_EN
    assign illegal     = (state_q == TRAP);
`endif

endmodule

// File: tb/tb_opcode_fetch_mod.sv
// tb/tb_opcode_fetch_mod.sv - self-checking bench for opcode_fetch_mod
module tb_opcode_fetch_mod;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  opcode;
    logic        cb_prefix;
    logic [15:0] imm;
    logic [15:0] instr_pc;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;
`ifdef OPFETCH_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    logic [7:0]  mem [0:65535];
    int          nwait = 0;
    int          wcnt;
    int          n_checks = 0;
    int          n_fail = 0;

    opcode_fetch_mod #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .cb_prefix(cb_prefix), .imm(imm), .instr_pc(instr_pc),
        .pc_load(pc_load), .pc_load_val(pc_load_val)
`ifdef OPFETCH_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    assign mem_ack   = mem_rd && (wcnt >= nwait);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (!mem_rd || mem_ack || pc_load) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    typedef struct packed {
        logic [7:0]  b0, b1, b2;
        logic [7:0]  nw;
        logic [7:0]  op;
        logic        cb;
        logic [15:0] imm;
        logic [15:0] pc;
        logic [7:0]  lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pc_load = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_opcode", opcode, 8'h00);
        chk("rst_cb", cb_prefix, 0);
        chk("rst_imm", imm, 16'h0000);
        chk("rst_instr_pc", instr_pc, 16'h0000);
`ifdef OPFETCH_ILLEGAL_TRAP_EN
        chk("rst_illegal", illegal, 0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rel_mem_rd", mem_rd, 1);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        forever begin
            @(posedge clk);
            #1;
            cycles++;
            if (instr_valid || cycles >= 60) break;
        end
    endtask

    vec_t vecs[10];
    int   nvec;
    int   cyc;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

        nvec = 0;
        vecs[nvec++] = '{8'h00, 8'h00, 8'h00, 8'd0, 8'h00, 1'b0, 16'h0000, 16'h0001, 8'd1};
        vecs[nvec++] = '{8'h01, 8'h34, 8'h12, 8'd0, 8'h01, 1'b0, 16'h1234, 16'h0003, 8'd3};
        vecs[nvec++] = '{8'h01, 8'h34, 8'h12, 8'd2, 8'h01, 1'b0, 16'h1234, 16'h0003, 8'd9};
        vecs[nvec++] = '{8'hCB, 8'h7C, 8'h00, 8'd0, 8'h7C, 1'b1, 16'h0000, 16'h0002, 8'd2};
        vecs[nvec++] = '{8'h3E, 8'h5A, 8'h00, 8'd0, 8'h3E, 1'b0, 16'h005A, 16'h0002, 8'd2};
        vecs[nvec++] = '{8'hC3, 8'h50, 8'h01, 8'd1, 8'hC3, 1'b0, 16'h0150, 16'h0003, 8'd6};
        vecs[nvec++] = '{8'hE0, 8'hFF, 8'h00, 8'd1, 8'hE0, 1'b0, 16'h00FF, 16'h0002, 8'd4};
        vecs[nvec++] = '{8'hCB, 8'h11, 8'h22, 8'd1, 8'h11, 1'b1, 16'h0000, 16'h0002, 8'd4};
        vecs[nvec++] = '{8'hFA, 8'hCD, 8'hAB, 8'd0, 8'hFA, 1'b0, 16'hABCD, 16'h0003, 8'd3};
`ifndef OPFETCH_ILLEGAL_TRAP_EN
        vecs[nvec++] = '{8'hD3, 8'h77, 8'h00, 8'd0, 8'hD3, 1'b0, 16'h0000, 16'h0001, 8'd1};
`endif

        for (int v = 0; v < nvec; v++) begin
            mem[0] = vecs[v].b0;
            mem[1] = vecs[v].b1;
            mem[2] = vecs[v].b2;
            mem[3] = 8'h00;
            nwait = int'(vecs[v].nw);
            do_reset();
            wait_valid(cyc);
            chk($sformatf("v%0d_latency", v), cyc, vecs[v].lat);
            chk($sformatf("v%0d_opcode", v), opcode, vecs[v].op);
            chk($sformatf("v%0d_cb", v), cb_prefix, vecs[v].cb);
            chk($sformatf("v%0d_imm", v), imm, vecs[v].imm);
            chk($sformatf("v%0d_instr_pc", v), instr_pc, 16'h0000);
            chk($sformatf("v%0d_pc", v), mem_addr, vecs[v].pc);
            chk($sformatf("v%0d_hold_rd", v), mem_rd, 0);
        end
        nwait = 0;

        // Consumer stall then handoff
        mem[0] = 8'h00; mem[1] = 8'h00;
        do_reset();
        wait_valid(cyc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", instr_valid, 1);
            chk("stall_rd", mem_rd, 0);
            chk("stall_opcode", opcode, 8'h00);
            chk("stall_addr", mem_addr, 16'h0001);
        end
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        chk("handoff_valid", instr_valid, 0);
        chk("handoff_rd", mem_rd, 1);
        chk("handoff_addr", mem_addr, 16'h0001);
        @(posedge clk); #1;
        chk("second_valid", instr_valid, 1);
        chk("second_instr_pc", instr_pc, 16'h0001);

        // Redirect during FETCH_LO coinciding with an ack
        mem[0] = 8'hC3; mem[1] = 8'hAA; mem[2] = 8'hBB; mem[16'h0150] = 8'h00;
        do_reset();
        @(posedge clk); #1;
        chk("redir_lo_addr", mem_addr, 16'h0001);
        pc_load = 1'b1; pc_load_val = 16'h0150;
        @(posedge clk); #1;
        pc_load = 1'b0;
        chk("redir_addr", mem_addr, 16'h0150);
        chk("redir_no_valid", instr_valid, 0);
        chk("redir_rd", mem_rd, 1);
        @(posedge clk); #1;
        chk("redir_valid", instr_valid, 1);
        chk("redir_opcode", opcode, 8'h00);
        chk("redir_instr_pc", instr_pc, 16'h0150);
        chk("redir_next_addr", mem_addr, 16'h0151);

        // PC wrap at FFFF
        mem[16'hFFFF] = 8'h00;
        do_reset();
        pc_load = 1'b1; pc_load_val = 16'hFFFF;
        @(posedge clk); #1;
        pc_load = 1'b0;
        chk("wrap_load_addr", mem_addr, 16'hFFFF);
        @(posedge clk); #1;
        chk("wrap_valid", instr_valid, 1);
        chk("wrap_instr_pc", instr_pc, 16'hFFFF);
        chk("wrap_addr", mem_addr, 16'h0000);

        // Asynchronous reset during a wait state
        mem[0] = 8'h01;
        nwait = 3;
        do_reset();
        @(posedge clk); #1;
        chk("async_pre_rd", mem_rd, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rd", mem_rd, 0);
        chk("async_addr", mem_addr, 16'h0000);
        chk("async_valid", instr_valid, 0);
        nwait = 0;

`ifdef OPFETCH_ILLEGAL_TRAP_EN
        mem[0] = 8'hD3; mem[16'h0100] = 8'h00;
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk("trap_illegal", illegal, 1);
            chk("trap_rd", mem_rd, 0);
            chk("trap_valid", instr_valid, 0);
            @(posedge clk); #1;
        end
        pc_load = 1'b1; pc_load_val = 16'h0100;
        @(posedge clk); #1;
        pc_load = 1'b0;
        chk("trap_clear", illegal, 0);
        chk("trap_resume_rd", mem_rd, 1);
        chk("trap_resume_addr", mem_addr, 16'h0100);
        @(posedge clk); #1;
        chk("trap_resume_valid", instr_valid, 1);
        chk("trap_resume_pc", instr_pc, 16'h0100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
